// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl
//  Description : Multi-cycle 32-bit integer divider for the execute stage.
//                Restoring radix-2 algorithm, one quotient bit per clock,
//                MSB first. Signed operation divides magnitudes and fixes the
//                signs afterwards. Divide-by-zero bypasses the iteration and
//                returns quotient = all ones, remainder = raw dividend.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   clock, rising-edge active
//    resetn         in   1   asynchronous reset, active low
//    div_enable     in   1   request; held high until the result is taken
//    div_signed     in   1   1 = signed divide, 0 = unsigned
//    div_src1       in  32   dividend
//    div_src2       in  32   divisor
//    div_out_ready  in   1   consumer accepts the result this cycle
//    div_cancel     in   1   flush; abandons any operation in progress
//    div_complete   out  1   quotient / remainder valid (DONE state)
//    div_busy       out  1   operation in progress (state not IDLE)
//    div_quotient   out 32   quotient
//    div_remainder  out 32   remainder
// ============================================================================
module div_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_enable,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        div_out_ready,
    input  logic        div_cancel,
    output logic        div_complete,
    output logic        div_busy,
    output logic [31:0] div_quotient,
    output logic [31:0] div_remainder
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_iter   = 2'd1;
    localparam logic [1:0] c_st_fix    = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [4:0] c_last_step = 5'd31;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]  state_q,    state_d;
    logic [4:0]  cnt_q,      cnt_d;       // iteration counter, wraps naturally
    logic [31:0] dvd_q,      dvd_d;       // dividend shifts out, quotient shifts in
    logic [31:0] dvs_q,      dvs_d;       // divisor magnitude
    logic [31:0] prem_q,     prem_d;      // partial remainder
    logic        sgn_mode_q, sgn_mode_d;  // latched div_signed
    logic        sgn1_q,     sgn1_d;      // dividend sign bit
    logic        sgn2_q,     sgn2_d;      // divisor sign bit
    logic        dzero_q,    dzero_d;     // divisor was zero
    logic [31:0] quot_q,     quot_d;
    logic [31:0] rem_q,      rem_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [31:0] w_src1_mag;
    logic [31:0] w_src2_mag;
    logic        w_src2_zero;
    logic [32:0] w_shift;      // partial remainder with next dividend bit
    logic [31:0] w_sub;        // trial difference
    logic        w_no_borrow;  // trial subtraction succeeds
    logic        w_neg_quot;
    logic        w_neg_rem;

    always_comb begin
        // Magnitudes are only taken in signed mode; unsigned operands pass
        // through untouched. 0x80000000 maps to itself, which is the correct
        // unsigned magnitude 2^31.
        w_src1_mag  = (div_signed && div_src1[31]) ? (32'd0 - div_src1) : div_src1;
        w_src2_mag  = (div_signed && div_src2[31]) ? (32'd0 - div_src2) : div_src2;
        w_src2_zero = (div_src2 == 32'd0);

        w_shift     = {prem_q, dvd_q[31]};
        w_no_borrow = (w_shift >= {1'b0, dvs_q});
        // When the subtraction succeeds the true result is below the divisor,
        // so dropping the top bit loses nothing.
        w_sub       = w_shift[31:0] - dvs_q;

        // Divide-by-zero results are delivered raw, with no sign fix-up.
        w_neg_quot  = sgn_mode_q && !dzero_q && (sgn1_q ^ sgn2_q);
        w_neg_rem   = sgn_mode_q && !dzero_q && sgn1_q;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Cancel overrides every other transition.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (div_cancel) begin
            state_d = c_st_idle;
        end else begin
            case (state_q)
                c_st_idle: begin
                    if (div_enable) begin
                        state_d = w_src2_zero ? c_st_fix : c_st_iter;
                    end
                end
                c_st_iter: begin
                    if (cnt_q == c_last_step) begin
                        state_d = c_st_fix;
                    end
                end
                c_st_fix: begin
                    state_d = c_st_done;
                end
                c_st_done: begin
                    if (div_out_ready) begin
                        state_d = c_st_idle;
                    end
                end
                default: begin
                    state_d = c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        div_complete = (state_q == c_st_done);
        div_busy     = (state_q != c_st_idle);
    end

    // ------------------------------------------------------------------
    // Datapath next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        prem_d     = prem_q;
        sgn_mode_d = sgn_mode_q;
        sgn1_d     = sgn1_q;
        sgn2_d     = sgn2_q;
        dzero_d    = dzero_q;
        quot_d     = quot_q;
        rem_d      = rem_q;

        if (!div_cancel) begin
            case (state_q)
                c_st_idle: begin
                    if (div_enable) begin
                        cnt_d      = 5'd0;
                        sgn_mode_d = div_signed;
                        sgn1_d     = div_src1[31];
                        sgn2_d     = div_src2[31];
                        dzero_d    = w_src2_zero;
                        if (w_src2_zero) begin
                            // Preload the final divide-by-zero answer so FIX
                            // just passes it through.
                            dvd_d  = 32'hFFFF_FFFF;
                            dvs_d  = div_src2;
                            prem_d = div_src1;
                        end else begin
                            dvd_d  = w_src1_mag;
                            dvs_d  = w_src2_mag;
                            prem_d = 32'd0;
                        end
                    end
                end
                c_st_iter: begin
                    cnt_d  = cnt_q + 5'd1;
                    dvd_d  = {dvd_q[30:0], w_no_borrow};
                    prem_d = w_no_borrow ? w_sub : w_shift[31:0];
                end
                c_st_fix: begin
                    quot_d = w_neg_quot ? (32'd0 - dvd_q)  : dvd_q;
                    rem_d  = w_neg_rem  ? (32'd0 - prem_q) : prem_q;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= 5'd0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
            prem_q     <= 32'd0;
            sgn_mode_q <= 1'b0;
            sgn1_q     <= 1'b0;
            sgn2_q     <= 1'b0;
            dzero_q    <= 1'b0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
        end else begin
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            prem_q     <= prem_d;
            sgn_mode_q <= sgn_mode_d;
            sgn1_q     <= sgn1_d;
            sgn2_q     <= sgn2_d;
            dzero_q    <= dzero_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

    assign div_quotient  = quot_q;
    assign div_remainder = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_ctrl
//  Description : Self-checking bench for div_ctrl. Directed steps followed by
//                random operands compared against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    logic        clk;
    logic        resetn;
    logic        div_enable;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_out_ready;
    logic        div_cancel;
    logic        div_complete;
    logic        div_busy;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    int total = 0;
    int bad   = 0;

    div_ctrl u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .div_enable    (div_enable),
        .div_signed    (div_signed),
        .div_src1      (div_src1),
        .div_src2      (div_src2),
        .div_out_ready (div_out_ready),
        .div_cancel    (div_cancel),
        .div_complete  (div_complete),
        .div_busy      (div_busy),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: divide magnitudes, then apply C-style signs.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        logic [63:0] ma, mb, mq, mr;
        logic        na, nb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            return;
        end
        na = s && a[31];
        nb = s && b[31];
        ma = {32'd0, a};
        mb = {32'd0, b};
        if (na) ma = 64'h1_0000_0000 - ma;
        if (nb) mb = 64'h1_0000_0000 - mb;
        mq = ma / mb;
        mr = ma % mb;
        if (na ^ nb) mq = 64'd0 - mq;
        if (na)      mr = 64'd0 - mr;
        q = mq[31:0];
        r = mr[31:0];
    endfunction

    // Caller sets the request at a falling edge; the next rising edge samples
    // it (counted as 1). Returns the edge count at which div_complete is seen.
    // Operands are scrambled while busy; the result must not depend on them.
    task automatic launch_and_wait(input logic [31:0] prev_q, input logic [31:0] prev_r,
                                   output int n);
        @(posedge clk);
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (div_complete === 1'b1) break;
            if (n == 3) begin
                chk("hold_q_busy", div_quotient, prev_q);
                chk("hold_r_busy", div_remainder, prev_r);
            end
            div_src1   = $urandom;
            div_src2   = $urandom;
            div_signed = 1'($urandom_range(0, 1));
            @(posedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] prev_q, input logic [31:0] prev_r, output int n);
        div_src1      = a;
        div_src2      = b;
        div_signed    = s;
        div_enable    = 1'b1;
        div_out_ready = 1'b0;
        launch_and_wait(prev_q, prev_r, n);
    endtask

    task automatic release_op();
        div_enable    = 1'b0;
        div_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_out_ready = 1'b0;
    endtask

    initial begin
        int          n;
        logic [31:0] eq, er, mq, mr, ra, rb;
        logic        rs;
        bit          saw_complete;

        resetn        = 1'b1;
        div_enable    = 1'b0;
        div_signed    = 1'b0;
        div_src1      = 32'd0;
        div_src2      = 32'd0;
        div_out_ready = 1'b0;
        div_cancel    = 1'b0;

        // Reset values, observed without any clock edge.
        #2 resetn = 1'b0;
        #1;
        chk("rst_busy", 32'(div_busy), 32'd0);
        chk("rst_complete", 32'(div_complete), 32'd0);
        chk("rst_quot", div_quotient, 32'd0);
        chk("rst_rem", div_remainder, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        eq = 32'd0;
        er = 32'd0;

        // Unsigned 100 / 7.
        run_op(32'd100, 32'd7, 1'b0, eq, er, n);
        chk("lat_100_7", 32'(n), 32'd34);
        chk("q_100_7", div_quotient, 32'h0000_000E);
        chk("r_100_7", div_remainder, 32'h0000_0002);
        release_op();
        chk("idle_busy", 32'(div_busy), 32'd0);
        chk("idle_complete", 32'(div_complete), 32'd0);
        eq = 32'h0000_000E;
        er = 32'h0000_0002;

        // Signed -7 / 2.
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, eq, er, n);
        chk("q_m7_2", div_quotient, 32'hFFFF_FFFD);
        chk("r_m7_2", div_remainder, 32'hFFFF_FFFF);
        release_op();
        eq = 32'hFFFF_FFFD;
        er = 32'hFFFF_FFFF;

        // Signed overflow.
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, eq, er, n);
        chk("q_ovf", div_quotient, 32'h8000_0000);
        chk("r_ovf", div_remainder, 32'h0000_0000);
        release_op();
        eq = 32'h8000_0000;
        er = 32'h0000_0000;

        // Divide by zero, signed mode must not alter the raw dividend.
        run_op(32'h1234_5678, 32'd0, 1'b1, eq, er, n);
        chk("lat_dz", 32'(n), 32'd2);
        chk("q_dz", div_quotient, 32'hFFFF_FFFF);
        chk("r_dz", div_remainder, 32'h1234_5678);
        release_op();
        eq = 32'hFFFF_FFFF;
        er = 32'h1234_5678;

        // Result held in DONE while the consumer stalls.
        run_op(32'd1000, 32'd7, 1'b0, eq, er, n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_complete", 32'(div_complete), 32'd1);
            chk("stall_q", div_quotient, 32'd142);
            chk("stall_r", div_remainder, 32'd6);
        end
        eq = 32'd142;
        er = 32'd6;

        // Back-to-back: accept with div_enable still high and new operands.
        div_out_ready = 1'b1;
        div_src1      = 32'd9;
        div_src2      = 32'd3;
        div_signed    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle_busy", 32'(div_busy), 32'd0);
        chk("b2b_idle_complete", 32'(div_complete), 32'd0);
        div_out_ready = 1'b0;
        launch_and_wait(eq, er, n);
        chk("lat_b2b", 32'(n), 32'd34);
        chk("q_b2b", div_quotient, 32'd3);
        chk("r_b2b", div_remainder, 32'd0);
        release_op();
        eq = 32'd3;
        er = 32'd0;

        // Cancel when the iteration counter reads 10.
        div_src1   = 32'h7FFF_FFFF;
        div_src2   = 32'd3;
        div_signed = 1'b0;
        div_enable = 1'b1;
        saw_complete = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (div_complete === 1'b1) saw_complete = 1'b1;
        end
        div_cancel = 1'b1;
        div_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        div_cancel = 1'b0;
        chk("cancel_busy", 32'(div_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (div_complete === 1'b1) saw_complete = 1'b1;
            @(negedge clk);
        end
        chk("cancel_no_complete", 32'(saw_complete), 32'd0);
        chk("cancel_q_kept", div_quotient, eq);
        chk("cancel_r_kept", div_remainder, er);

        run_op(32'd50, 32'd5, 1'b0, eq, er, n);
        chk("lat_50_5", 32'(n), 32'd34);
        chk("q_50_5", div_quotient, 32'd10);
        chk("r_50_5", div_remainder, 32'd0);
        release_op();
        eq = 32'd10;
        er = 32'd0;

        // Random operands against the model.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = 32'h0000_0000 - 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, mq, mr);
            run_op(ra, rb, rs, eq, er, n);
            chk("rnd_lat", 32'(n), (rb == 32'd0) ? 32'd2 : 32'd34);
            chk("rnd_q", div_quotient, mq);
            chk("rnd_r", div_remainder, mr);
            release_op();
            eq = mq;
            er = mr;
        end

        // Asynchronous reset in the middle of ITER, with nonzero results held.
        run_op(32'd1000, 32'd7, 1'b0, eq, er, n);
        release_op();
        div_src1   = 32'hDEAD_BEEF;
        div_src2   = 32'h0000_1234;
        div_enable = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(div_busy), 32'd0);
        chk("arst_complete", 32'(div_complete), 32'd0);
        chk("arst_quot", div_quotient, 32'd0);
        chk("arst_rem", div_remainder, 32'd0);
        div_enable = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("arst_idle_busy", 32'(div_busy), 32'd0);

        run_op(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, n);
        chk("post_rst_lat", 32'(n), 32'd34);
        chk("post_rst_q", div_quotient, 32'h0000_000E);
        chk("post_rst_r", div_remainder, 32'h0000_0002);
        release_op();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 resetn  input  1  asynchronous active-low reset; clears all state immediately when low.
REQ-003 div_enable  input  1  request from the execute stage; held high until the result is accepted.
REQ-004 div_signed  input  1  1 = signed divide, 0 = unsigned; sampled with the operands.
REQ-005 div_src1  input  32  dividend (rj value).
REQ-006 div_src2  input  32  divisor (rkd value).
REQ-007 div_out_ready  input  1  consumer accepts the result this cycle (execute stage may advance).
REQ-008 div_cancel  input  1  flush; abandons any operation in progress.
REQ-009 div_complete  output  1  quotient and remainder are valid.
REQ-010 div_busy  output  1  an operation is in progress (state not IDLE).
REQ-011 div_quotient  output  32  quotient.
REQ-012 div_remainder  output  32  remainder.

Function
REQ-013 FSM states SHALL be IDLE, ITER, FIX and DONE.
REQ-014 IDLE with div_enable=1 and div_cancel=0: latch the absolute values of the operands (when div_signed), the operand signs and div_signed, clear the 5-bit iteration counter, go to ITER.
REQ-015 Operands are captured only in IDLE; later changes on div_src1/div_src2/div_signed SHALL be ignored until the next IDLE.
REQ-016 ITER: one restoring radix-2 step per cycle (shift the partial remainder left by 1 with the next dividend bit; subtract the divisor when there is no borrow and set the quotient bit), MSB first.
REQ-017 ITER lasts exactly 32 cycles; the counter increments each cycle; counter==31 moves to FIX; the counter wraps to 0.
REQ-018 Divisor==0 detected in IDLE: skip ITER, go straight to FIX with quotient=0xFFFFFFFF and remainder=raw div_src1; FIX applies no sign correction in this case.
REQ-019 FIX: in signed mode, negate the quotient when the operand signs differ and negate the remainder when the dividend is negative; register the results; go to DONE.
REQ-020 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 with no special casing.
REQ-021 DONE: div_complete=1 and the outputs are held stable; div_out_ready=1 moves to IDLE next cycle; otherwise the block stays in DONE indefinitely.
REQ-022 div_complete SHALL be high only in DONE; div_busy SHALL be high in ITER, FIX and DONE.
REQ-023 Latency: a normal operation asserts div_complete 34 cycles after the edge that sampled div_enable in IDLE. A divide-by-zero asserts it 2 cycles after that edge.
REQ-024 Back-to-back operations: after DONE->IDLE, a still-high div_enable starts a new operation on the IDLE cycle, using the current operands.
REQ-025 div_cancel=1 in any state moves to IDLE next cycle; div_complete drops that cycle. Cancel wins over a simultaneous div_enable or div_out_ready.
REQ-026 div_quotient and div_remainder keep their last values in IDLE and ITER, and change only on the FIX edge.

Reset
REQ-027 With resetn=0: state=IDLE, counter=0, div_complete=0, div_busy=0, div_quotient=0, div_remainder=0, independent of clk.
REQ-028 Reset asserted mid-operation (any state) SHALL abort the operation. After deassertion the block waits in IDLE for div_enable.

Verification
REQ-029 Unsigned 100 / 7, div_out_ready=1 -> div_complete after 34 cycles, quotient=0x0000000E, remainder=0x00000002, then IDLE.
REQ-030 Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-031 Divisor 0, dividend 0x12345678 -> div_complete after 2 cycles, quotient=0xFFFFFFFF, remainder=0x12345678.
REQ-032 div_out_ready held 0 for 5 cycles in DONE -> div_complete and the results stable for all 5 cycles. Then div_out_ready=1 with div_enable kept high and new operands 9/3 -> second result quotient=3, remainder=0.
REQ-033 div_cancel pulsed at ITER counter=10 -> IDLE next cycle, div_complete never asserted. A following 50/5 request completes normally with quotient=10, remainder=0.
REQ-034 resetn driven low asynchronously mid-ITER (between clock edges) -> div_busy, div_complete and the outputs are 0 before the next edge.
